router1_grant_sched: RTL and testbench
======================================

// Module: router1_grant_sched
// PURPOSE
//  Clocked grant scheduler for the three 2:1 output merges of a router1 node (outputs P, C1, C2).
//  - Collects per-output routing requests from the input decoders.
//  - Arbitrates round-robin between the two candidate inputs of each output.
//  - Issues one grant token per packet and holds the output locked until the tail flit has passed.
//  - Sits between the decoder/select splits and the merge select channels.
// PARAMETERS
//  NUM_OUT        3   number of outputs; topology fixes this at 3 (0=P, 1=C1, 2=C2)
//  MAX_PKT_FLITS  16  flits allowed per packet before pkt_len_err is set
//  WDOG_CYCLES    64  idle cycles in BUSY before abort (ROUTER1_ARB_WDOG_EN only)
// PORTS
//  CLK          in   1          clock
//  RESET        in   1          asynchronous, active-high reset
//  req          in   NUM_OUT*2  req[2o+k]: candidate k wants output o
//                               o=P: k0=C1, k1=C2; o=C1: k0=C2, k1=P; o=C2: k0=C1, k1=P
//  grant_valid  out  NUM_OUT    grant token valid toward merge o
//  grant_sel    out  NUM_OUT    granted candidate (0=In0, 1=In1 of merge o)
//  grant_ready  in   NUM_OUT    merge o accepts the grant token
//  flit_fire    in   NUM_OUT    a flit transferred on output o this cycle
//  flit_tail    in   NUM_OUT    the fired flit is the packet tail (qualified by flit_fire)
//  busy         out  NUM_OUT    output o granted or locked (state != IDLE)
//  pkt_len_err  out  NUM_OUT    sticky: packet exceeded MAX_PKT_FLITS flits
//  wdog_err     out  NUM_OUT    sticky: watchdog abort occurred (tied 0 without the macro)
// BEHAVIOUR
//  Reset values (all outputs): grant_valid=0, grant_sel=0, busy=0, pkt_len_err=0, wdog_err=0.
//  Reset internal state: every output in IDLE, rr_ptr=0 (candidate 0 favoured), flit_cnt=0.
//  RESET asserted mid-packet drops every output to IDLE immediately; no pending grant survives.
//  Per-output FSM, with independent and identical instances:
//   IDLE:  if any req[2o+k], register sel and enter ISSUE.
//          Only one candidate requesting: sel = that k. Both requesting: sel = rr_ptr.
//          No request: stay in IDLE.
//   ISSUE: grant_valid=1; grant_sel=sel held stable until the handshake.
//          On grant_valid & grant_ready: enter BUSY, flit_cnt=0.
//          A req drop while in ISSUE is ignored; the grant is not withdrawn.
//   BUSY:  flit_fire increments flit_cnt, which saturates at MAX_PKT_FLITS.
//          A fire when flit_cnt==MAX_PKT_FLITS sets pkt_len_err; the output stays locked.
//          flit_fire & flit_tail: enter IDLE; rr_ptr <= ~sel.
//  Latency:
//   - req to grant_valid: 1 cycle.
//   - Tail fire to the next grant_valid on the same output: 2 cycles (IDLE evaluates once).
//  flit_fire outside BUSY is ignored, including fire in the same cycle as the grant handshake.
//  Fairness: with both candidates requesting continuously, grants strictly alternate per packet.
//  Candidates are not mutually exclusive across outputs; requests are routed per output by the decoders.
//  flit_cnt width = $clog2(MAX_PKT_FLITS+1).
// CONFIGURATION
//  ROUTER1_ARB_WDOG_EN defined:
//   - Per-output idle counter, cleared on entering BUSY and on every flit_fire.
//   - Counter reaching WDOG_CYCLES-1 in BUSY: set wdog_err, go to IDLE, rr_ptr <= ~sel.
//   - Tail and timeout in the same cycle: tail wins; no error.
//  ROUTER1_ARB_WDOG_EN undefined: no counter; wdog_err tied 0; BUSY waits on tail indefinitely.
// STRUCTURE
//  Package router1_arb_pkg:
//   - arb_state_e {IDLE, ISSUE, BUSY}.
//   - Output index constants OUT_P=0, OUT_C1=1, OUT_C2=2.
//   - Candidate-to-input mapping table.
//   - Flit-count width function.
//  Sub-module router1_port_arb holds one output's FSM, rr_ptr, flit_cnt and watchdog.
//  The top level instantiates it NUM_OUT times via generate and only slices the buses.
// TESTING
//  1. Reset, then req[0]=1 at cycle 0 -> grant_valid[0]=1, grant_sel[0]=0 at cycle 1;
//     grant_ready=1 -> busy[0]=1 and grant_valid[0]=0 the next cycle.
//  2. req[1:0]=2'b11 held, four 3-flit packets with tail on flit 3 -> grant_sel[0] = 0,1,0,1;
//     each new grant_valid comes 2 cycles after its tail fire.
//  3. 17 flit_fire on output 1 with no tail (MAX_PKT_FLITS=16) -> pkt_len_err[1]=1 on the 17th fire;
//     busy[1] stays 1 until the tail.
//  4. ROUTER1_ARB_WDOG_EN set, BUSY with no fire for 64 cycles -> wdog_err[2]=1, busy[2]=0,
//     next grant goes to the other candidate.
//  5. RESET pulsed during BUSY on all outputs -> every output at its reset value in the same cycle;
//     after release, a held req gets a grant 1 cycle later.
//  6. flit_fire=1 during ISSUE and in the handshake cycle -> flit_cnt remains 0; tail ignored.

Source files
------------

// File: rtl/router1_arb_pkg.sv
// Shared types and constants for the router1 grant scheduler.
//   arb_state_e     : per-output arbiter state
//   OUT_P/C1/C2     : output indices
//   IN_P/C1/C2      : input indices used by the candidate mapping
//   cand_input()    : which router input is candidate k of output o
//   flit_cnt_width(): width of a counter that must hold 0..max
package router1_arb_pkg;

  localparam int unsigned NUM_OUT = 3;

  localparam int unsigned OUT_P  = 0;
  localparam int unsigned OUT_C1 = 1;
  localparam int unsigned OUT_C2 = 2;

  localparam logic [1:0] IN_P  = 2'd0;
  localparam logic [1:0] IN_C1 = 2'd1;
  localparam logic [1:0] IN_C2 = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_e;

  // Candidate-to-input table: P <- {C1, C2}, C1 <- {C2, P}, C2 <- {C1, P}.
  function automatic logic [1:0] cand_input(input int unsigned o, input logic k);
    logic [1:0] in_id;
    case (o)
      OUT_P:   in_id = k ? IN_C2 : IN_C1;
      OUT_C1:  in_id = k ? IN_P  : IN_C2;
      default: in_id = k ? IN_P  : IN_C1;
    endcase
    return in_id;
  endfunction

  function automatic int unsigned flit_cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/router1_port_arb.sv
// One output's 2:1 grant arbiter: round-robin pick, grant token, packet lock.
// Optional watchdog under ROUTER1_ARB_WDOG_EN.
// Ports:
//   CLK, RESET      clock, asynchronous active-high reset
//   req[1:0]        candidate k requests this output
//   grant_valid     grant token valid (registered)
//   grant_sel       granted candidate, stable while grant_valid
//   grant_ready     merge accepts the token
//   flit_fire/tail  flit transferred / it was the tail
//   busy            state != IDLE
//   pkt_len_err     sticky, packet longer than MAX_PKT_FLITS
//   wdog_err        sticky, watchdog abort (0 without the macro)
module router1_port_arb
  import router1_arb_pkg::*;
#(
  parameter int unsigned MAX_PKT_FLITS = 16
`ifdef ROUTER1_ARB_WDOG_EN
  , parameter int unsigned WDOG_CYCLES = 64
`endif
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] req,
  output logic       grant_valid,
  output logic       grant_sel,
  input  logic       grant_ready,
  input  logic       flit_fire,
  input  logic       flit_tail,
  output logic       busy,
  output logic       pkt_len_err,
  output logic       wdog_err
);

  localparam int unsigned CNT_W = flit_cnt_width(MAX_PKT_FLITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT_FLITS);

  arb_state_e       state_q, state_n;
  logic             sel_q, sel_n;
  logic             rr_q, rr_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             len_err_n;
  logic             grant_valid_n;
  logic             busy_n;

`ifdef ROUTER1_ARB_WDOG_EN
  localparam int unsigned WD_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_CYCLES - 1);
  logic [WD_W-1:0] wcnt_q, wcnt_n;
  logic            wdog_n;
`endif

  // Next-state and output decode.
  always_comb begin
    state_n   = state_q;
    sel_n     = sel_q;
    rr_n      = rr_q;
    cnt_n     = cnt_q;
    len_err_n = pkt_len_err;
`ifdef ROUTER1_ARB_WDOG_EN
    wcnt_n    = wcnt_q;
    wdog_n    = wdog_err;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          // Both requesting: round-robin pointer decides; otherwise the lone requester.
          sel_n   = (req == 2'b11) ? rr_q : req[1];
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        // grant_valid is always high here, so ready alone completes the handshake.
        if (grant_ready) begin
          state_n = BUSY;
          cnt_n   = '0;
`ifdef ROUTER1_ARB_WDOG_EN
          wcnt_n  = '0;
`endif
        end
      end
      BUSY: begin
        if (flit_fire) begin
          if (cnt_q == CNT_MAX) len_err_n = 1'b1;
          else                  cnt_n     = cnt_q + CNT_W'(1);
`ifdef ROUTER1_ARB_WDOG_EN
          wcnt_n = '0;
`endif
          if (flit_tail) begin
            state_n = IDLE;
            rr_n    = ~sel_q;
          end
        end
`ifdef ROUTER1_ARB_WDOG_EN
        else if (wcnt_q == WD_MAX) begin
          wdog_n  = 1'b1;
          state_n = IDLE;
          rr_n    = ~sel_q;
        end else begin
          wcnt_n = wcnt_q + WD_W'(1);
        end
`endif
      end
      default: state_n = IDLE;
    endcase
    grant_valid_n = (state_n == ISSUE);
    busy_n        = (state_n != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      pkt_len_err <= 1'b0;
      grant_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_n;
      sel_q       <= sel_n;
      rr_q        <= rr_n;
      cnt_q       <= cnt_n;
      pkt_len_err <= len_err_n;
      grant_valid <= grant_valid_n;
      busy        <= busy_n;
    end
  end

  assign grant_sel = sel_q;

`ifdef ROUTER1_ARB_WDOG_EN
  // Watchdog counter and sticky abort flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wcnt_q   <= '0;
      wdog_err <= 1'b0;
    end else begin
      wcnt_q   <= wcnt_n;
      wdog_err <= wdog_n;
    end
  end
`else
  assign wdog_err = 1'b0;
`endif

endmodule

// File: rtl/router1_grant_sched.sv
// Grant scheduler for the three 2:1 output merges (P, C1, C2) of a router1 node.
// Build option: ROUTER1_ARB_WDOG_EN enables the per-output BUSY watchdog.
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   req[2o+k]             candidate k wants output o
//   grant_valid/sel[o]    grant token toward merge o
//   grant_ready[o]        merge o accepts the token
//   flit_fire/tail[o]     flit transferred on output o / tail flit
//   busy[o]               output o granted or locked
//   pkt_len_err[o]        sticky packet-length error
//   wdog_err[o]           sticky watchdog abort
module router1_grant_sched
  import router1_arb_pkg::*;
#(
  parameter int unsigned MAX_PKT_FLITS = 16
`ifdef ROUTER1_ARB_WDOG_EN
  , parameter int unsigned WDOG_CYCLES = 64
`endif
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_OUT*2-1:0] req,
  output logic [NUM_OUT-1:0]   grant_valid,
  output logic [NUM_OUT-1:0]   grant_sel,
  input  logic [NUM_OUT-1:0]   grant_ready,
  input  logic [NUM_OUT-1:0]   flit_fire,
  input  logic [NUM_OUT-1:0]   flit_tail,
  output logic [NUM_OUT-1:0]   busy,
  output logic [NUM_OUT-1:0]   pkt_len_err,
  output logic [NUM_OUT-1:0]   wdog_err
);

  // One independent arbiter per output; the top only slices buses.
  for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
    router1_port_arb #(
      .MAX_PKT_FLITS(MAX_PKT_FLITS)
`ifdef ROUTER1_ARB_WDOG_EN
      , .WDOG_CYCLES(WDOG_CYCLES)
`endif
    ) u_arb (
      .CLK        (CLK),
      .RESET      (RESET),
      .req        (req[2*o +: 2]),
      .grant_valid(grant_valid[o]),
      .grant_sel  (grant_sel[o]),
      .grant_ready(grant_ready[o]),
      .flit_fire  (flit_fire[o]),
      .flit_tail  (flit_tail[o]),
      .busy       (busy[o]),
      .pkt_len_err(pkt_len_err[o]),
      .wdog_err   (wdog_err[o])
    );
  end

endmodule

// File: tb/tb_router1_grant_sched.sv
// Directed self-checking bench for router1_grant_sched.
module tb_router1_grant_sched;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [5:0] req;
  logic [2:0] grant_valid, grant_sel, grant_ready;
  logic [2:0] flit_fire, flit_tail;
  logic [2:0] busy, pkt_len_err, wdog_err;

  int n_tests = 0;
  int n_fail  = 0;

  router1_grant_sched dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .req        (req),
    .grant_valid(grant_valid),
    .grant_sel  (grant_sel),
    .grant_ready(grant_ready),
    .flit_fire  (flit_fire),
    .flit_tail  (flit_tail),
    .busy       (busy),
    .pkt_len_err(pkt_len_err),
    .wdog_err   (wdog_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    req = '0; grant_ready = '0; flit_fire = '0; flit_tail = '0;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset values, single request, handshake
    do_reset();
    check("rst_gv",   32'(grant_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err",  32'(pkt_len_err), 32'h0);
    check("rst_wdog", 32'(wdog_err), 32'h0);
    req = 6'b000001;
    tick();
    check("t1_gv",   32'(grant_valid), 32'b001);
    check("t1_sel",  32'(grant_sel[0]), 32'h0);
    check("t1_busy_issue", 32'(busy), 32'b001);
    grant_ready = 3'b001;
    tick();
    grant_ready = '0;
    check("t1_gv_after_hs", 32'(grant_valid), 32'b000);
    check("t1_busy", 32'(busy), 32'b001);
    req = '0; flit_fire = 3'b001; flit_tail = 3'b001;
    tick();
    flit_fire = '0; flit_tail = '0;
    check("t1_busy_tail", 32'(busy), 32'b000);

    // 2: round-robin alternation, 2-cycle tail-to-grant
    do_reset();
    req = 6'b000011;
    for (int p = 0; p < 4; p++) begin
      tick();
      check($sformatf("t2_gv_p%0d", p), 32'(grant_valid[0]), 32'h1);
      check($sformatf("t2_sel_p%0d", p), 32'(grant_sel[0]), 32'(p % 2));
      grant_ready = 3'b001;
      tick();
      grant_ready = '0;
      check($sformatf("t2_busy_p%0d", p), 32'(busy[0]), 32'h1);
      for (int f = 0; f < 3; f++) begin
        flit_fire = 3'b001;
        flit_tail = (f == 2) ? 3'b001 : 3'b000;
        tick();
      end
      flit_fire = '0; flit_tail = '0;
      check($sformatf("t2_idle_p%0d", p), 32'({busy[0], grant_valid[0]}), 32'h0);
    end
    tick();
    check("t2_regrant", 32'(grant_valid[0]), 32'h1);

    // 3: length overflow on output 1
    do_reset();
    req = 6'b000100;
    tick();
    check("t3_gv", 32'(grant_valid), 32'b010);
    check("t3_sel", 32'(grant_sel[1]), 32'h0);
    grant_ready = 3'b010;
    tick();
    grant_ready = '0; req = '0;
    flit_fire = 3'b010;
    for (int f = 0; f < 16; f++) tick();
    check("t3_err16", 32'(pkt_len_err[1]), 32'h0);
    tick();
    check("t3_err17", 32'(pkt_len_err[1]), 32'h1);
    check("t3_busy17", 32'(busy[1]), 32'h1);
    flit_fire = '0;
    tick();
    check("t3_busy_hold", 32'(busy[1]), 32'h1);
    flit_fire = 3'b010; flit_tail = 3'b010;
    tick();
    flit_fire = '0; flit_tail = '0;
    check("t3_busy_tail", 32'(busy[1]), 32'h0);
    check("t3_err_sticky", 32'(pkt_len_err), 32'b010);

    // 6: fire/tail during ISSUE and in the handshake cycle are ignored
    do_reset();
    req = 6'b100000;
    tick();
    check("t6_gv", 32'(grant_valid), 32'b100);
    check("t6_sel", 32'(grant_sel[2]), 32'h1);
    flit_fire = 3'b100; flit_tail = 3'b100;
    tick();
    check("t6_gv_hold", 32'(grant_valid[2]), 32'h1);
    grant_ready = 3'b100;
    tick();
    grant_ready = '0; req = '0;
    check("t6_busy", 32'({busy[2], grant_valid[2]}), 32'b10);
    flit_tail = '0;
    for (int f = 0; f < 16; f++) tick();
    flit_fire = '0;
    check("t6_cnt_clean", 32'(pkt_len_err[2]), 32'h0);
    check("t6_busy16", 32'(busy[2]), 32'h1);

`ifdef ROUTER1_ARB_WDOG_EN
    // 4: watchdog abort on output 2, then the other candidate is granted
    do_reset();
    req = 6'b110000;
    tick();
    check("t4_sel0", 32'(grant_sel[2]), 32'h0);
    grant_ready = 3'b100;
    tick();
    grant_ready = '0;
    for (int c = 0; c < 63; c++) tick();
    check("t4_busy63", 32'({busy[2], wdog_err[2]}), 32'b10);
    tick();
    check("t4_abort", 32'({busy[2], wdog_err[2]}), 32'b01);
    tick();
    check("t4_regrant", 32'(grant_valid[2]), 32'h1);
    check("t4_sel1", 32'(grant_sel[2]), 32'h1);
`endif

    // 5: asynchronous reset during BUSY on all outputs
    do_reset();
    req = 6'b010101;
    tick();
    check("t5_gv", 32'(grant_valid), 32'b111);
    grant_ready = 3'b111;
    tick();
    grant_ready = '0;
    check("t5_busy", 32'(busy), 32'b111);
    #2;
    RESET = 1'b1;
    #1;
    check("t5_async", 32'({grant_valid, grant_sel, busy, pkt_len_err, wdog_err}), 32'h0);
    tick();
    #2;
    RESET = 1'b0;
    tick();
    check("t5_regrant", 32'(grant_valid), 32'b111);
    check("t5_sel", 32'(grant_sel), 32'b000);
    check("t5_wdog_none", 32'(wdog_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
